linia_fifo: RTL and testbench
=============================

LINIA_FIFO -- requirements
Module: linia_fifo

Interface
REQ-001 Parameter N, default 2: data word width in bits, N >= 1.
REQ-002 Parameter DEPTH, default 4: storage depth in words, a power of two, DEPTH >= 2.
REQ-003 Parameter CW = $clog2(DEPTH+1): width of the fill count.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 clr  input  1: synchronous flush, active-high.
REQ-007 idata  input  N: write word, normally taken from an upstream fixed-latency delay line.
REQ-008 ivalid  input  1: idata is valid this cycle; there is no upstream ready, so the source cannot stall.
REQ-009 odata  output  N: head-of-queue word.
REQ-010 ovalid  output  1: odata is valid.
REQ-011 oready  input  1: downstream accepts odata.
REQ-012 count  output  CW: number of words stored, range 0..DEPTH.
REQ-013 full  output  1: count == DEPTH.
REQ-014 ovf  output  1: sticky overflow flag.

Function
REQ-015 Define rd = ovalid && oready, the pop event.
REQ-016 Define wr = ivalid && (!full || rd), the accepted push event.
REQ-017 A push writes idata to mem[wr_ptr] and advances wr_ptr modulo DEPTH.
REQ-018 A pop advances rd_ptr modulo DEPTH.
REQ-019 Pointer wrap from DEPTH-1 to 0 shall be seamless, with no lost or duplicated word.
REQ-020 odata shall equal mem[rd_ptr], read combinationally from the register array.
REQ-021 ovalid shall equal (count != 0).
REQ-022 odata is don't-care while ovalid is 0.
REQ-023 There is no fall-through: a word pushed in cycle t shall first appear on odata with ovalid=1 in cycle t+1.
REQ-024 count shall be updated as follows:
- +1 on wr && !rd
- -1 on rd && !wr
- unchanged on wr && rd, or on neither
REQ-025 When full and rd=1, a simultaneous ivalid shall be accepted; count stays DEPTH.
REQ-026 When empty, rd is impossible because ovalid=0; a push moves count from 0 to 1.
REQ-027 Drop rule: ivalid && full && !rd shall discard idata and leave mem, pointers and count unchanged.
REQ-028 On a drop, ovf shall be 1 from the next cycle onward.
REQ-029 ovf shall be cleared only by reset or clr.
REQ-030 clr=1 shall, at the next edge, set wr_ptr, rd_ptr and count to 0 and ovf to 0.
REQ-031 clr has priority: any concurrent push, pop or drop in that cycle shall be ignored and shall not set ovf.
REQ-032 mem contents need not be cleared by clr or reset.
REQ-033 ovalid and oready must not feed back combinationally to ivalid; the only combinational paths are:
- oready -> wr
- full -> wr
- rd_ptr -> odata
REQ-034 The block shall contain no internal state machine beyond the pointers, count and ovf.

Reset
REQ-035 rst_n=0 shall immediately, without waiting for a clk edge, force the following, held while rst_n=0:
- wr_ptr=0, rd_ptr=0
- count=0, full=0, ovalid=0, ovf=0
REQ-036 After rst_n rises, the first push shall be accepted on the first rising edge at which ivalid=1.
REQ-037 Reset asserted mid-operation shall discard all stored words; no stale word shall appear on odata with ovalid=1 after release.

Verification
REQ-038 Fill and drain, N=8, DEPTH=4: push 0x11, 0x22, 0x33, 0x44 with oready=0 -> count=4, full=1, ovf=0; then oready=1 -> odata reads 0x11..0x44 on consecutive cycles, then ovalid=0.
REQ-039 Overflow: full with 0x11..0x44, push 0x55 with oready=0 -> 0x55 dropped, ovf=1 next cycle, count=4; drain yields 0x11..0x44 only; ovf stays 1 until clr.
REQ-040 Full with simultaneous pop and push, full with 0x11..0x44: ivalid=1, idata=0x55, oready=1 -> 0x11 popped, 0x55 accepted, count=4, ovf=0; drain yields 0x22, 0x33, 0x44, 0x55.
REQ-041 Wrap-around: continuous ivalid=1 and oready=1 for 3*DEPTH cycles with an incrementing pattern -> output sequence equals input delayed by 1 cycle, count alternates 1/1 steady, no gaps after the first word.
REQ-042 clr priority: with count=3 and ovf=1, assert clr with ivalid=1 and oready=1 -> next cycle count=0, ovalid=0, ovf=0, and nothing pushed.
REQ-043 Async reset mid-stream: with count=2, pulse rst_n low between clk edges -> count=0, ovalid=0 before the next edge; after release, push 0xA5 -> odata=0xA5 one cycle later.

Source files
------------

// File: rtl/linia_fifo.sv
// Register-array FIFO that sits after a source with no backpressure.
// Words that arrive while the queue is full are dropped, and the sticky ovf flag records the loss.
module linia_fifo #(
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [N-1:0]  idata,
  input  logic          ivalid,
  output logic [N-1:0]  odata,
  output logic          ovalid,
  input  logic          oready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic          rd;
  logic          wr;
  logic          drop;

  assign full   = (count_reg == CW'(DEPTH));
  assign ovalid = (count_reg != '0);
  assign rd     = ovalid & oready;
  // A pop in the same cycle frees a slot, so a full queue can still accept a word.
  assign wr     = ivalid & (~full | rd);
  assign drop   = ivalid & full & ~rd;
  assign odata  = mem[rd_ptr_reg];
  assign count  = count_reg;
  assign ovf    = ovf_reg;

  // Storage has no reset. A stale word cannot appear, because ovalid depends only on count.
  always_ff @(posedge clk) begin
    if (wr && !clr) begin
      mem[wr_ptr_reg] <= idata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the natural wrap of the pointer width gives the modulo.
      if (wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr, rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_linia_fifo.sv
// Directed bench for linia_fifo with a queue-based reference model.
// The model is checked on every falling edge, and literal checks pin down the key scenarios.
module tb_linia_fifo;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  idata = '0;
  logic          ivalid = 1'b0;
  logic [N-1:0]  odata;
  logic          ovalid;
  logic          oready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] q[$];
  bit           m_ovf = 1'b0;

  linia_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .idata(idata), .ivalid(ivalid),
    .odata(odata), .ovalid(ovalid), .oready(oready), .count(count),
    .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the overflow bit.
  always @(negedge rst_n) begin
    q.delete();
    m_ovf = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (clr) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        bit pop, push;
        pop  = (q.size() > 0) && oready;
        push = ivalid && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(idata);
        if (ivalid && !push) m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_count", 32'(count), 32'(q.size()));
    check("model_full", 32'(full), 32'(q.size() == DEPTH));
    check("model_ovalid", 32'(ovalid), 32'(q.size() != 0));
    check("model_ovf", 32'(ovf), 32'(m_ovf));
    if (q.size() != 0) check("model_odata", 32'(odata), 32'(q[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] c, input logic [N-1:0] d, input int n);
    logic [N-1:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    oready = 1'b0;
    for (int i = 0; i < n; i++) begin
      ivalid = 1'b1;
      idata  = w[i];
      cyc();
    end
    ivalid = 1'b0;
  endtask

  task automatic drain_expect(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [N-1:0] c, input logic [N-1:0] d, input string tag);
    logic [N-1:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_ovalid"}, 32'(ovalid), 32'd1);
      check({tag, "_odata"}, 32'(odata), 32'(w[i]));
      cyc();
    end
    check({tag, "_empty"}, 32'(ovalid), 32'd0);
    oready = 1'b0;
  endtask

  initial begin
    // Reset state, held while rst_n is low
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Fill and drain
    push_words(8'h11, 8'h22, 8'h33, 8'h44, 4);
    check("fill_count", 32'(count), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(ovf), 32'd0);
    drain_expect(8'h11, 8'h22, 8'h33, 8'h44, "drain1");

    // Overflow drop
    push_words(8'h11, 8'h22, 8'h33, 8'h44, 4);
    ivalid = 1'b1; idata = 8'h55; cyc(); ivalid = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    drain_expect(8'h11, 8'h22, 8'h33, 8'h44, "drain_ovf");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // clr priority with count=3, ovf=1
    push_words(8'h11, 8'h22, 8'h33, 8'h00, 3);
    check("pre_clr_count", 32'(count), 32'd3);
    check("pre_clr_ovf", 32'(ovf), 32'd1);
    clr = 1'b1; ivalid = 1'b1; oready = 1'b1; idata = 8'h99;
    cyc();
    clr = 1'b0; ivalid = 1'b0; oready = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_ovalid", 32'(ovalid), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);

    // Full with a simultaneous pop and push
    push_words(8'h11, 8'h22, 8'h33, 8'h44, 4);
    ivalid = 1'b1; idata = 8'h55; oready = 1'b1;
    check("fpp_head", 32'(odata), 32'h11);
    cyc();
    ivalid = 1'b0;
    check("fpp_count", 32'(count), 32'd4);
    check("fpp_ovf", 32'(ovf), 32'd0);
    drain_expect(8'h22, 8'h33, 8'h44, 8'h55, "drain_fpp");

    // Wrap-around streaming: output equals input delayed by one cycle
    ivalid = 1'b1; oready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      idata = 8'(8'h60 + i);
      cyc();
      check("wrap_ovalid", 32'(ovalid), 32'd1);
      check("wrap_odata", 32'(odata), 32'(8'h60 + i));
      check("wrap_count", 32'(count), 32'd1);
    end
    ivalid = 1'b0;
    cyc();
    oready = 1'b0;
    check("wrap_end_ovalid", 32'(ovalid), 32'd0);

    // Async reset mid-stream
    push_words(8'h01, 8'h02, 8'h00, 8'h00, 2);
    check("pre_rst_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovalid", 32'(ovalid), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    ivalid = 1'b1; idata = 8'hA5;
    cyc();
    ivalid = 1'b0;
    check("post_rst_ovalid", 32'(ovalid), 32'd1);
    check("post_rst_odata", 32'(odata), 32'hA5);
    check("post_rst_count", 32'(count), 32'd1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
